prg_loader: RTL and testbench
=============================

# prg_loader

Streaming writer that deposits a C64 PRG image into system RAM. It accepts a byte stream through a valid/ready handshake and takes the first two bytes as the little-endian load address. Each following byte is written to consecutive RAM addresses, but only in cycles where the memory grants a write slot. It sits between the host/SD byte source and the RAM port mux, and reports the end address (BASIC end-of-program pointer) on completion.

## Interface
- aw, 16, RAM address width
- dw, 8, RAM data width (stream byte is zero-extended if dw > 8)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; (re)arms loader from any state
- s_valid  in  1  stream byte valid
- s_data  in  8  stream byte
- s_last  in  1  marks final byte of image, qualified by s_valid
- s_ready  out  1  loader accepts byte this cycle
- wr_slot  in  1  memory grants a write slot this cycle
- mem_we  out  1  write strobe, one cycle per byte
- mem_addr  out  aw  write address
- mem_do  out  dw  write data
- busy  out  1  state is not IDLE, DONE or ERR
- done  out  1  level; image fully written
- err  out  1  level; short header or address overflow
- end_addr  out  aw  address one past last written byte, valid when done=1

## Operation
- States: IDLE, ADDR_LO, ADDR_HI, DATA, DONE, ERR. Reset -> IDLE.
- start in any state -> ADDR_LO. Clears done, err and the pending write. start has priority over all other events; s_ready=0 in the cycle start is high.
- IDLE / DONE: s_ready=0, s_valid ignored.
- ADDR_LO: s_ready=1. Accept -> ptr[7:0]=s_data, go ADDR_HI.
- ADDR_HI: s_ready=1. Accept -> ptr[15:8]=s_data, go DATA.
- s_last accepted in ADDR_LO or ADDR_HI -> ERR (short header).
- DATA: one-byte holding register with a pend flag.
  - s_ready = !pend | wr_slot.
  - Accept -> hold=s_data, pend=1, last_r=s_last.
  - mem_we = pend & wr_slot (combinational). mem_addr=ptr, mem_do=hold.
  - On a write edge: pend cleared (or reloaded if a byte is accepted in the same cycle), ptr+1.
  - Write of the byte with last_r=1 -> end_addr=ptr+1, go DONE, done=1.
- Overflow: ptr is aw bits. A write at ptr=all-ones is performed; ptr then wraps to 0. Any further byte accepted -> ERR, and that byte is not written.
- ERR: err=1, s_ready=1. Bytes are drained and discarded until s_last is accepted, then s_ready=0. Stays in ERR until start.
- Empty data section (header followed by s_last on ADDR_HI) is an error, not a zero-length load.

## Timing
- Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_do=0, busy=0, done=0, err=0, end_addr=0. Internal ptr, hold, pend and last_r are cleared.
- s_ready, mem_we, busy, done and err are decoded from registered state only. mem_we additionally ANDs in wr_slot. There is no combinational path from s_valid to s_ready.
- Write latency: byte accepted at edge N is written at the first edge ≥ N+1 where wr_slot=1.
- Throughput: 1 byte/cycle when wr_slot is held high; 1 byte per slot otherwise.
- done/err rise on the edge after the terminating write/accept and hold until start.
- end_addr is registered together with the DONE transition.
- Asynchronous reset mid-load discards the pending byte; no mem_we is issued.

## Test plan
- Basic load: start; stream 01 08 A9 00 60 (last on 60), wr_slot=1 -> writes A9@0801, 00@0802, 60@0803; done=1, end_addr=0804.
- Slotted writes: same stream, wr_slot high every 2nd cycle -> s_ready stalls while pend is set with no slot; identical writes, each mem_we coincident with wr_slot.
- Backpressure/gaps: random s_valid gaps -> no duplicate or missing writes, address strictly sequential.
- Short header: start; 01 with s_last -> err=1, no mem_we, busy=0.
- Overflow: header FE FF, data 11 22 33 (last on 33) -> 11@FFFE, 22@FFFF, then err=1; 33 drained, not written.
- Restart and reset: start mid-DATA with pend=1 -> pending byte dropped, state ADDR_LO. rst low mid-load -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/prg_loader_if.sv
// Byte-stream and RAM write-port bundle for the PRG loader.
// "slave" is the loader side; "master" is the byte source plus memory arbiter.
interface prg_loader_if #(
    parameter int aw = 16,
    parameter int dw = 8
);
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_last;
    logic          s_ready;
    logic          wr_slot;
    logic          mem_we;
    logic [aw-1:0] mem_addr;
    logic [dw-1:0] mem_do;

    modport master (
        output s_valid, s_data, s_last, wr_slot,
        input  s_ready, mem_we, mem_addr, mem_do
    );

    modport slave (
        input  s_valid, s_data, s_last, wr_slot,
        output s_ready, mem_we, mem_addr, mem_do
    );
endinterface

// File: rtl/prg_loader.sv
// Streams a C64 PRG image (2-byte little-endian load address + payload) into RAM,
// writing one byte per granted slot and reporting the end-of-program address.
module prg_loader #(
    parameter int aw = 16,
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    prg_loader_if.slave   bus,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [aw-1:0] end_addr
);
    typedef enum logic [2:0] {IDLE, ADDR_LO, ADDR_HI, DATA, DONE, ERR} state_t;

    state_t        state;
    logic [aw-1:0] ptr;
    logic [7:0]    hold;
    logic          pend;
    logic          last_r;
    logic          ovf;
    logic          drain;
    logic          rdy;
    logic          accept;
    logic          wr;
    logic          wrap;

    always_comb begin
        rdy = 1'b0;
        if (!start) begin
            unique case (state)
                ADDR_LO, ADDR_HI: rdy = 1'b1;
                DATA:             rdy = !pend | bus.wr_slot;
                ERR:              rdy = drain;
                default:          rdy = 1'b0;
            endcase
        end
    end

    assign accept       = bus.s_valid & rdy;
    assign wr           = pend & bus.wr_slot & !start;
    // A write at the top address wraps ptr; any byte accepted alongside or after it overflows.
    assign wrap         = wr & (&ptr);

    assign bus.s_ready  = rdy;
    assign bus.mem_we   = wr;
    assign bus.mem_addr = ptr;
    assign bus.mem_do   = dw'(hold);

    assign busy = (state == ADDR_LO) || (state == ADDR_HI) || (state == DATA);
    assign done = (state == DONE);
    assign err  = (state == ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold     <= '0;
            pend     <= 1'b0;
            last_r   <= 1'b0;
            ovf      <= 1'b0;
            drain    <= 1'b0;
            end_addr <= '0;
        end else if (start) begin
            state  <= ADDR_LO;
            pend   <= 1'b0;
            last_r <= 1'b0;
            ovf    <= 1'b0;
            drain  <= 1'b0;
        end else begin
            unique case (state)
                ADDR_LO: begin
                    if (accept) begin
                        if (bus.s_last) begin
                            state <= ERR;
                            drain <= 1'b0;
                        end else begin
                            ptr[7:0] <= bus.s_data;
                            state    <= ADDR_HI;
                        end
                    end
                end
                ADDR_HI: begin
                    if (accept) begin
                        if (bus.s_last) begin
                            state <= ERR;
                            drain <= 1'b0;
                        end else begin
                            ptr[15:8] <= bus.s_data;
                            state     <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (wr) begin
                        ptr  <= ptr + 1'b1;
                        pend <= 1'b0;
                        if (wrap)
                            ovf <= 1'b1;
                        if (last_r) begin
                            end_addr <= ptr + 1'b1;
                            state    <= DONE;
                        end
                    end
                    // A byte arriving with the final write belongs to no image and is dropped.
                    if (accept && !(wr && last_r)) begin
                        if (ovf || wrap) begin
                            state <= ERR;
                            drain <= !bus.s_last;
                            pend  <= 1'b0;
                        end else begin
                            hold   <= bus.s_data;
                            pend   <= 1'b1;
                            last_r <= bus.s_last;
                        end
                    end
                end
                ERR: begin
                    if (accept && bus.s_last)
                        drain <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_prg_loader.sv
// Directed bench for prg_loader: expected RAM writes are queued as bytes are sent
// and matched against every mem_we strobe.
module tb_prg_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [15:0] end_addr;

    int checks = 0;
    int failures = 0;
    int nwr = 0;
    int stall_cnt = 0;
    int mode = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t exp_q[$];

    prg_loader_if #(.aw(16), .dw(8)) bus ();

    prg_loader #(.aw(16), .dw(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus.slave),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .end_addr (end_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // wr_slot pattern: 0 always granted, 1 alternating, 2 random, otherwise never granted
    initial begin
        bus.wr_slot = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       bus.wr_slot = 1'b1;
                1:       bus.wr_slot = ~bus.wr_slot;
                2:       bus.wr_slot = 1'($urandom_range(0, 1));
                default: bus.wr_slot = 1'b0;
            endcase
        end
    end

    // Scoreboard side: every strobe must coincide with a slot and match the queue head.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (busy && bus.s_valid && !bus.s_ready)
                stall_cnt++;
            if (bus.mem_we) begin
                nwr++;
                check("we_with_slot", 32'(bus.wr_slot), 1);
                check("wr_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.mem_addr), 32'(e.a));
                    check("wr_data", 32'(bus.mem_do), 32'(e.d));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        check("start_rdy_low", 32'(bus.s_ready), 0);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        bit ok = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        bus.s_last  = last;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                ok = 1;
                break;
            end
        end
        check("send_accepted", 32'(ok), 1);
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
    endtask

    task automatic wait_flag(input string tag, input bit want_err);
        bit seen = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (want_err ? err : done) begin
                seen = 1;
                break;
            end
        end
        check(tag, 32'(seen), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back('{a: a, d: d});
    endtask

    initial begin
        int w0;
        logic [7:0] d;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 32'(bus.s_ready), 0);
        check("rst_mem_we", 32'(bus.mem_we), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_mem_do", 32'(bus.mem_do), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_end_addr", 32'(end_addr), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Idle ignores stream
        bus.s_valid = 1'b1;
        @(negedge clk);
        check("idle_rdy", 32'(bus.s_ready), 0);
        @(posedge clk);
        #1 bus.s_valid = 1'b0;

        // Basic load, slot always granted
        mode = 0;
        pulse_start();
        @(negedge clk);
        check("basic_busy", 32'(busy), 1);
        @(posedge clk);
        #1;
        push(16'h0801, 8'hA9); push(16'h0802, 8'h00); push(16'h0803, 8'h60);
        w0 = nwr;
        send(8'h01, 0); send(8'h08, 0); send(8'hA9, 0); send(8'h00, 0); send(8'h60, 1);
        wait_flag("basic_done", 0);
        check("basic_end_addr", 32'(end_addr), 32'h0804);
        check("basic_nwr", 32'(nwr - w0), 3);
        check("basic_q_empty", 32'(exp_q.size()), 0);
        check("basic_busy_end", 32'(busy), 0);
        check("basic_err", 32'(err), 0);
        bus.s_valid = 1'b1;
        @(negedge clk);
        check("done_rdy", 32'(bus.s_ready), 0);
        @(posedge clk);
        #1 bus.s_valid = 1'b0;

        // Slotted writes, slot every other cycle
        mode = 1;
        stall_cnt = 0;
        pulse_start();
        push(16'h0801, 8'hA9); push(16'h0802, 8'h00); push(16'h0803, 8'h60);
        w0 = nwr;
        send(8'h01, 0); send(8'h08, 0); send(8'hA9, 0); send(8'h00, 0); send(8'h60, 1);
        wait_flag("slot_done", 0);
        check("slot_end_addr", 32'(end_addr), 32'h0804);
        check("slot_nwr", 32'(nwr - w0), 3);
        check("slot_stalled", 32'(stall_cnt > 0), 1);
        check("slot_q_empty", 32'(exp_q.size()), 0);

        // Random source gaps and random slots
        mode = 2;
        pulse_start();
        w0 = nwr;
        send(8'h00, 0); send(8'hC0, 0);
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom_range(0, 255));
            push(16'hC000 + 16'(i), d);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(d, i == 19);
        end
        wait_flag("gap_done", 0);
        check("gap_end_addr", 32'(end_addr), 32'hC014);
        check("gap_nwr", 32'(nwr - w0), 20);
        check("gap_q_empty", 32'(exp_q.size()), 0);

        // Short header
        mode = 0;
        pulse_start();
        w0 = nwr;
        send(8'h01, 1);
        wait_flag("short_err", 1);
        check("short_busy", 32'(busy), 0);
        check("short_done", 32'(done), 0);
        check("short_rdy", 32'(bus.s_ready), 0);
        check("short_nwr", 32'(nwr - w0), 0);

        // Address overflow
        pulse_start();
        w0 = nwr;
        push(16'hFFFE, 8'h11); push(16'hFFFF, 8'h22);
        send(8'hFE, 0); send(8'hFF, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 1);
        wait_flag("ovf_err", 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ovf_nwr", 32'(nwr - w0), 2);
        check("ovf_done", 32'(done), 0);
        check("ovf_rdy_drained", 32'(bus.s_ready), 0);
        check("ovf_q_empty", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;

        // Restart while a byte is pending
        mode = 3;
        pulse_start();
        send(8'h00, 0); send(8'h10, 0); send(8'h55, 0);
        pulse_start();
        @(negedge clk);
        check("restart_busy", 32'(busy), 1);
        check("restart_rdy", 32'(bus.s_ready), 1);
        check("restart_we", 32'(bus.mem_we), 0);
        @(posedge clk);
        #1 mode = 0;
        w0 = nwr;
        push(16'h2000, 8'h77);
        send(8'h00, 0); send(8'h20, 0); send(8'h77, 1);
        wait_flag("restart_done", 0);
        check("restart_end_addr", 32'(end_addr), 32'h2001);
        check("restart_nwr", 32'(nwr - w0), 1);

        // Asynchronous reset mid-load
        mode = 3;
        pulse_start();
        send(8'h00, 0); send(8'h30, 0); send(8'h99, 0);
        mode = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_s_ready", 32'(bus.s_ready), 0);
        check("arst_mem_we", 32'(bus.mem_we), 0);
        check("arst_mem_addr", 32'(bus.mem_addr), 0);
        check("arst_mem_do", 32'(bus.mem_do), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_err", 32'(err), 0);
        check("arst_end_addr", 32'(end_addr), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("arst_idle_we", 32'(bus.mem_we), 0);
        check("final_q_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
